// File: rtl/synth_voice_sequencer.sv
// rtl/synth_voice_sequencer.sv - per-voice register bank and shared voice datapath sequencer
module synth_voice_sequencer #(
  parameter int NUM_VOICES = 16,
  parameter int BITDEPTH   = 14,
  parameter int MIX_SHIFT  = 2,
  parameter int DP_TIMEOUT = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          addr,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  input  logic                wen,
  input  logic                ren,
  output logic                ready,
  input  logic                sample_tick,
  output logic                dp_start,
  output logic [3:0]          dp_voice,
  output logic [6:0]          dp_note,
  output logic [6:0]          dp_tuning,
  output logic [7:0]          dp_attack,
  output logic [7:0]          dp_decay,
  output logic                dp_gate,
  input  logic                dp_done,
  input  logic [BITDEPTH-1:0] dp_sample,
  output logic [BITDEPTH-1:0] mix_out,
  output logic                mix_valid,
  output logic                overrun
);
  localparam int ACC_W = BITDEPTH + 4;
  localparam int CNT_W = $clog2(DP_TIMEOUT + 1);
  localparam logic [ACC_W-1:0] MAX_MIX = ACC_W'((1 << BITDEPTH) - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // bank word layout: tuning[30:24] attack[23:16] decay[15:8] note[7:1] gate[0]
  logic [30:0]           bank [NUM_VOICES];
  logic [NUM_VOICES-1:0] valid;
  logic                  ack;
  logic                  access;
  logic                  addr_ok;
  state_t                state;
  logic [3:0]            idx;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      shifted;
  logic [CNT_W-1:0]      tcnt;
  logic                  last;

  assign access  = (wen || ren) && !ack;
  assign addr_ok = ({28'd0, addr} < 32'(NUM_VOICES));
  assign ready   = ack && (wen || ren);
  assign last    = (idx == 4'(NUM_VOICES - 1));
  assign shifted = acc >> MIX_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack      <= 1'b0;
      data_out <= '0;
      valid    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) bank[i] <= '0;
    end else begin
      if (access) ack <= 1'b1;
      else if (!wen && !ren) ack <= 1'b0;
      if (access && wen && addr_ok) begin
        valid[addr] <= 1'b1;
        // a non-config write only retunes the note/gate pair
        if (data_in[31]) bank[addr] <= data_in[30:0];
        else bank[addr] <= {bank[addr][30:8], data_in[7:0]};
      end
      if (access && ren) data_out <= addr_ok ? {valid[addr], bank[addr]} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      tcnt      <= '0;
      dp_start  <= 1'b0;
      dp_voice  <= '0;
      dp_note   <= '0;
      dp_tuning <= '0;
      dp_attack <= '0;
      dp_decay  <= '0;
      dp_gate   <= 1'b0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dp_start  <= 1'b0;
      mix_valid <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_tick) begin
          acc   <= '0;
          idx   <= '0;
          state <= ISSUE;
        end
        ISSUE: if (valid[idx]) begin
          {dp_tuning, dp_attack, dp_decay, dp_note, dp_gate} <= bank[idx];
          dp_voice <= idx;
          dp_start <= 1'b1;
          tcnt     <= '0;
          state    <= WAIT;
        end else if (last) begin
          state <= DONE;
        end else begin
          idx <= idx + 4'd1;
        end
        WAIT: if (dp_done || tcnt == CNT_W'(DP_TIMEOUT - 1)) begin
          // a voice that never answers contributes silence
          if (dp_done) acc <= acc + ACC_W'(dp_sample);
          else overrun <= 1'b1;
          if (last) state <= DONE;
          else begin
            idx   <= idx + 4'd1;
            state <= ISSUE;
          end
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        DONE: begin
          mix_out   <= (shifted > MAX_MIX) ? BITDEPTH'(MAX_MIX) : shifted[BITDEPTH-1:0];
          mix_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_synth_voice_sequencer.sv
// tb/tb_synth_voice_sequencer.sv - self-checking bench for synth_voice_sequencer
module tb_synth_voice_sequencer;
  logic        clk, rst;
  logic [3:0]  addr;
  logic [31:0] data_in, data_out;
  logic        wen, ren, ready, sample_tick;
  logic        dp_start, dp_gate, dp_done, mix_valid, overrun;
  logic [3:0]  dp_voice;
  logic [6:0]  dp_note, dp_tuning;
  logic [7:0]  dp_attack, dp_decay;
  logic [13:0] dp_sample, mix_out;

  synth_voice_sequencer dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
    .wen(wen), .ren(ren), .ready(ready), .sample_tick(sample_tick),
    .dp_start(dp_start), .dp_voice(dp_voice), .dp_note(dp_note), .dp_tuning(dp_tuning),
    .dp_attack(dp_attack), .dp_decay(dp_decay), .dp_gate(dp_gate),
    .dp_done(dp_done), .dp_sample(dp_sample),
    .mix_out(mix_out), .mix_valid(mix_valid), .overrun(overrun)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int          val [16];
  int          lat [16];
  bit          hang [16];
  logic [15:0] started;
  int          start_count;
  int          pass_cnt = 0;
  int          total    = 0;

  // datapath model: answers each dp_start after lat[v] cycles with val[v]
  initial begin
    dp_done = 0;
    dp_sample = 0;
    forever begin
      @(negedge clk);
      if (dp_start && !rst) begin
        int v;
        v = int'(dp_voice);
        started[v] = 1'b1;
        start_count++;
        if (!hang[v]) begin
          repeat (lat[v] - 1) @(negedge clk);
          dp_done = 1;
          dp_sample = 14'(val[v]);
          @(negedge clk);
          dp_done = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int model_mix(input logic [15:0] mask);
    int s = 0;
    for (int v = 0; v < 16; v++) if (mask[v] && !hang[v]) s += val[v];
    s = s >> 2;
    return (s > 16383) ? 16383 : s;
  endfunction

  task automatic do_reset();
    rst = 1; wen = 0; ren = 0; sample_tick = 0;
    for (int v = 0; v < 16; v++) begin val[v] = 0; lat[v] = 5; hang[v] = 0; end
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    addr = a; data_in = d; wen = 1;
    do begin @(negedge clk); n++; end while (!ready && n < 10);
    chk("wr_ready", 32'(ready), 1);
    wen = 0; #1;
    chk("wr_ready_drop", 32'(ready), 0);
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    addr = a; ren = 1;
    do begin @(negedge clk); n++; end while (!ready && n < 10);
    chk("rd_ready", 32'(ready), 1);
    d = data_out;
    ren = 0; #1;
    chk("rd_ready_drop", 32'(ready), 0);
    @(negedge clk);
  endtask

  task automatic run_frame(input int extra_at, output int mix, output int pulses, output int lat_c);
    started = '0; start_count = 0;
    sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
    mix = -1; pulses = 0; lat_c = -1;
    for (int c = 0; c < 1500; c++) begin
      sample_tick = (c == extra_at);
      if (mix_valid) begin
        pulses++;
        if (lat_c < 0) begin lat_c = c; mix = int'(mix_out); end
      end
      if (lat_c >= 0 && c > lat_c + 4) break;
      @(negedge clk);
    end
    sample_tick = 0;
  endtask

  task automatic frame_check(input string name, input logic [15:0] mask, input int extra_at);
    int m, p, l;
    run_frame(extra_at, m, p, l);
    chk({name, "_done"}, 32'(l >= 0), 1);
    chk({name, "_mix"}, 32'(m), 32'(model_mix(mask)));
    chk({name, "_pulses"}, 32'(p), 1);
    chk({name, "_started"}, 32'(started), 32'(mask));
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] rd;
  logic [15:0] mask;
  logic [31:0] r;
  int          m, p, l;

  initial begin
    vecs[0] = '{4'd0, 32'h80F0_4079, 32'h80F0_4079};
    vecs[1] = '{4'd0, 32'h0000_0078, 32'h80F0_4078};
    vecs[2] = '{4'd3, 32'h7F12_3456, 32'h8000_0056};
    vecs[3] = '{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{4'd7, 32'h8102_0304, 32'h8102_0304};
    vecs[5] = '{4'd3, 32'h0000_0001, 32'hFFFF_FF01};
    addr = 0; data_in = 0;
    do_reset();

    chk("rst_data_out", data_out, 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_dp_start", 32'(dp_start), 0);
    chk("rst_dp_fields", {dp_voice, dp_note, dp_tuning, dp_attack, dp_gate}, 0);
    chk("rst_mix", {mix_out, mix_valid, overrun}, 0);

    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].a, vecs[i].d);
      bus_read(vecs[i].a, rd);
      chk($sformatf("vec%0d_read", i), rd, vecs[i].exp);
    end
    bus_read(4'd9, rd);
    chk("unwritten_read", rd, 0);

    // single voice, datapath answers 1000 after 5 cycles
    do_reset();
    bus_write(4'd0, 32'h80F0_4079);
    val[0] = 1000;
    frame_check("voice0", 16'h0001, -1);
    chk("voice0_starts", 32'(start_count), 1);
    chk("voice0_dp", {dp_voice, dp_note, dp_attack, dp_decay, dp_gate}, {4'd0, 7'd60, 8'hF0, 8'h40, 1'b1});
    chk("voice0_overrun", 32'(overrun), 0);

    // no valid voices: tick to mix_valid takes NUM_VOICES+2 cycles
    do_reset();
    run_frame(-1, m, p, l);
    chk("empty_mix", 32'(m), 0);
    chk("empty_lat", 32'(l), 17);
    chk("empty_started", 32'(started), 0);

    do_reset();
    foreach (mask[v]) ;
    mask = 16'h8022;
    for (int v = 0; v < 16; v++) if (mask[v]) begin
      bus_write(4'(v), 32'h8000_0001 | (32'(v) << 1));
      val[v] = 16383;
      lat[v] = 2;
    end
    frame_check("sparse", mask, -1);

    for (int v = 0; v < 16; v++) begin
      bus_write(4'(v), 32'h8000_0003);
      val[v] = 16383;
    end
    frame_check("saturate", 16'hFFFF, -1);
    chk("saturate_val", 32'(mix_out), 16383);

    // voice 3 never answers
    do_reset();
    for (int v = 2; v < 5; v++) begin
      bus_write(4'(v), 32'h8000_0011);
      val[v] = 400;
    end
    hang[3] = 1;
    frame_check("hang", 16'h001C, -1);
    chk("hang_overrun", 32'(overrun), 1);

    // second tick while the frame is in flight
    do_reset();
    bus_write(4'd0, 32'h80F0_4079);
    val[0] = 1000;
    chk("pre_tick_overrun", 32'(overrun), 0);
    frame_check("dbl_tick", 16'h0001, 3);
    chk("dbl_tick_overrun", 32'(overrun), 1);

    // reset during WAIT abandons the frame
    do_reset();
    bus_write(4'd0, 32'h80F0_4079);
    val[0] = 1000;
    frame_check("pre_rst", 16'h0001, -1);
    lat[0] = 20;
    started = '0; start_count = 0;
    sample_tick = 1; @(negedge clk); sample_tick = 0;
    for (int c = 0; c < 40 && start_count == 0; c++) @(negedge clk);
    chk("rst_wait_started", 32'(start_count), 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_wait_dp", {dp_start, dp_voice, dp_note, dp_tuning, dp_attack, dp_decay, dp_gate}, 0);
    chk("rst_wait_mix", {mix_out, mix_valid, overrun, ready}, 0);
    rst = 0;
    p = 0;
    for (int c = 0; c < 40; c++) begin
      if (mix_valid) p++;
      @(negedge clk);
    end
    chk("rst_wait_no_mix", 32'(p), 0);

    // randomized voice subsets against the reference sum
    for (int it = 0; it < 4; it++) begin
      do_reset();
      mask = 16'($urandom_range(1, 16'hFFFF));
      for (int v = 0; v < 16; v++) if (mask[v]) begin
        r = $urandom;
        r[31] = 1'b1;
        bus_write(4'(v), r);
        val[v] = int'($urandom_range(0, 16383));
        lat[v] = int'($urandom_range(1, 8));
      end
      frame_check($sformatf("rand%0d", it), mask, -1);
      chk($sformatf("rand%0d_overrun", it), 32'(overrun), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
